// File: rtl/fifo_sync_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param_if
//  Brief    : Handshake/status bundle between a FIFO producer/consumer and
//             the fifo_sync_param storage block.
//  Revision : 1.0  initial release
// ============================================================================
interface fifo_sync_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic              i_flush;
  logic              i_clr_err;
  logic              i_wr_en;
  logic [DATA_W-1:0] i_data_in;
  logic              i_rd_en;
  logic [DATA_W-1:0] o_data_out;
  logic              o_fifo_full;
  logic              o_fifo_empty;
  logic              o_almost_full;
  logic              o_almost_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              o_underflow;

  // Requesting side: register file / shifter drives requests, observes status.
  modport master (
    output i_flush,
    output i_clr_err,
    output i_wr_en,
    output i_data_in,
    output i_rd_en,
    input  o_data_out,
    input  o_fifo_full,
    input  o_fifo_empty,
    input  o_almost_full,
    input  o_almost_empty,
    input  o_count,
    input  o_overflow,
    input  o_underflow
  );

  modport slave (
    input  i_flush,
    input  i_clr_err,
    input  i_wr_en,
    input  i_data_in,
    input  i_rd_en,
    output o_data_out,
    output o_fifo_full,
    output o_fifo_empty,
    output o_almost_full,
    output o_almost_empty,
    output o_count,
    output o_overflow,
    output o_underflow
  );

endinterface
`default_nettype wire

// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : fifo_sync_param
//  Brief    : Parametrised single-clock show-ahead FIFO with occupancy count,
//             almost-full/empty thresholds, flush and sticky error flags.
//  Revision : 1.0  initial release
// ============================================================================
module fifo_sync_param #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2
) (
  input  wire logic         i_clk,
  input  wire logic         i_rst_n,
  fifo_sync_param_if.slave  bus
);

  localparam int              c_DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] c_PTR_ONE   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] c_AFULL_TH  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] c_AEMPTY_TH = (ADDR_W+1)'(AEMPTY_TH);

  if (AFULL_TH > c_DEPTH) begin : g_bad_afull_th
    $error("fifo_sync_param: AFULL_TH must not exceed DEPTH");
  end
  if (AEMPTY_TH >= c_DEPTH) begin : g_bad_aempty_th
    $error("fifo_sync_param: AEMPTY_TH must be below DEPTH");
  end

  logic [DATA_W-1:0] r_mem [c_DEPTH];
  logic [ADDR_W:0]   r_wptr;
  logic [ADDR_W:0]   r_rptr;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_empty;
  logic              w_full;
  logic [ADDR_W:0]   w_count;
  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_ovf_set;
  logic              w_unf_set;

  // Extra wrap bit on each pointer distinguishes full from empty.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[ADDR_W] != r_rptr[ADDR_W]) &&
                   (r_wptr[ADDR_W-1:0] == r_rptr[ADDR_W-1:0]);
  assign w_count = r_wptr - r_rptr;

  // A read in the same cycle frees a slot, so a write while full still lands.
  assign w_rd_ok = bus.i_rd_en & ~w_empty;
  assign w_wr_ok = bus.i_wr_en & (~w_full | w_rd_ok);

  assign w_ovf_set = bus.i_wr_en & w_full & ~w_rd_ok & ~bus.i_flush;
  assign w_unf_set = bus.i_rd_en & w_empty & ~bus.i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (bus.i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + c_PTR_ONE;
      if (w_rd_ok) r_rptr <= r_rptr + c_PTR_ONE;
    end
  end

  // Storage is deliberately not reset; flush leaves contents untouched.
  always_ff @(posedge i_clk) begin
    if (w_wr_ok && !bus.i_flush) begin
      r_mem[r_wptr[ADDR_W-1:0]] <= bus.i_data_in;
    end
  end

  // Sticky flags: a new error in the clearing cycle takes precedence.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= w_ovf_set | (r_overflow  & ~bus.i_clr_err);
      r_underflow <= w_unf_set | (r_underflow & ~bus.i_clr_err);
    end
  end

  assign bus.o_data_out     = r_mem[r_rptr[ADDR_W-1:0]];
  assign bus.o_fifo_full    = w_full;
  assign bus.o_fifo_empty   = w_empty;
  assign bus.o_almost_full  = (w_count >= c_AFULL_TH);
  assign bus.o_almost_empty = (w_count <= c_AEMPTY_TH);
  assign bus.o_count        = w_count;
  assign bus.o_overflow     = r_overflow;
  assign bus.o_underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_sync_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fifo_sync_param
//  Brief    : Scoreboard bench for fifo_sync_param (16x16, thresholds 12/2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fifo_sync_param;

  localparam int c_DEPTH = 16;

  logic i_clk;
  logic i_rst_n;

  fifo_sync_param_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  fifo_sync_param #(
    .DATA_W    (16),
    .ADDR_W    (4),
    .AFULL_TH  (12),
    .AEMPTY_TH (2)
  ) u_dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] sb[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_status();
    int n;
    n = sb.size();
    check("count",    32'(bus.o_count),        32'(n));
    check("full",     32'(bus.o_fifo_full),    32'(n == c_DEPTH));
    check("empty",    32'(bus.o_fifo_empty),   32'(n == 0));
    check("afull",    32'(bus.o_almost_full),  32'(n >= 12));
    check("aempty",   32'(bus.o_almost_empty), 32'(n <= 2));
    check("overflow", 32'(bus.o_overflow),     32'(m_ovf));
    check("underflow",32'(bus.o_underflow),    32'(m_unf));
    check("full_and_empty", 32'(bus.o_fifo_full & bus.o_fifo_empty), 32'(0));
  endtask

  // Drive one cycle of requests, predict the outcome, then check after the edge.
  task automatic cycle(input logic wr, input logic [15:0] din, input logic rd,
                       input logic fl, input logic clr);
    logic        rd_ok, wr_ok, ovf_set, unf_set;
    logic [15:0] exp_d;
    bus.i_wr_en   = wr;
    bus.i_data_in = din;
    bus.i_rd_en   = rd;
    bus.i_flush   = fl;
    bus.i_clr_err = clr;
    #1;
    rd_ok   = rd && (sb.size() != 0);
    wr_ok   = wr && ((sb.size() != c_DEPTH) || rd_ok);
    ovf_set = wr && (sb.size() == c_DEPTH) && !rd_ok && !fl;
    unf_set = rd && (sb.size() == 0) && !fl;
    if (rd_ok && !fl) begin
      exp_d = sb.pop_front();
      check("rd_data", 32'(bus.o_data_out), 32'(exp_d));
    end
    if (fl) sb.delete();
    else if (wr_ok) sb.push_back(din);
    m_ovf = ovf_set | (m_ovf & ~clr);
    m_unf = unf_set | (m_unf & ~clr);
    @(posedge i_clk);
    #1;
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_clr_err = 1'b0;
    check_status();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.i_wr_en   = 1'b0;
    bus.i_rd_en   = 1'b0;
    bus.i_flush   = 1'b0;
    bus.i_clr_err = 1'b0;
    bus.i_data_in = '0;
    i_rst_n       = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    check_status();
    i_rst_n = 1'b1;

    // Fill to full; almost-full rises at 12.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
    check("full_after_16", 32'(bus.o_fifo_full), 32'(1));

    // Dropped 17th write sets sticky overflow.
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    check("ovf_set", 32'(bus.o_overflow), 32'(1));
    for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("ovf_sticky", 32'(bus.o_overflow), 32'(1));
    check("empty_after_drain", 32'(bus.o_fifo_empty), 32'(1));
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Write plus read while full.
    for (int i = 0; i < 16; i++) cycle(1'b1, 16'h1000 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);
    check("wr_rd_full_cnt", 32'(bus.o_count), 32'(16));
    for (int i = 0; i < 16; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // Underflow set/clear, set wins over clear.
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("unf_set", 32'(bus.o_underflow), 32'(1));
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("unf_clr", 32'(bus.o_underflow), 32'(0));
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);
    check("unf_set_wins", 32'(bus.o_underflow), 32'(1));
    cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Write while empty with a read request: read rejected, write lands.
    cycle(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    check("wr_empty_data", 32'(bus.o_data_out), 32'(16'h5A5A));
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b1);

    // Flush beats simultaneous write/read and raises no errors.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h2FFF, 1'b1, 1'b1, 1'b0);
    check("flush_cnt", 32'(bus.o_count), 32'(0));

    // Streaming with read offset 3, crossing pointer wraps.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 16'hA000 + 16'(i), (i >= 3), 1'b0, 1'b0);
      if (i >= 3) check("stream_cnt", 32'(bus.o_count), 32'(3));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle takes effect before the next edge.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'h3000 + 16'(i), 1'b0, 1'b0, 1'b0);
    #2;
    i_rst_n = 1'b0;
    #1;
    sb.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check("async_rst_cnt", 32'(bus.o_count), 32'(0));
    check("async_rst_empty", 32'(bus.o_fifo_empty), 32'(1));
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    check_status();
    cycle(1'b1, 16'h4444, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
